// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: drives a parallel pattern out MSB-first on one serial line.
// The frame repeats with optional idle gaps, the line idles at IDLE_BIT, and done pulses at the end.
// Ports:
//   clk, rst (sync, active-high)
//   start, pattern, len, repeats : transmission request and the frame it describes
//   pause                        : holds the current bit while in SEND
//   x, bit_valid                 : serial line and its live-bit qualifier
//   busy, done, err              : status outputs (done and err are one-cycle pulses)
module serial_pattern_tx #(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 4,
    parameter int GAP_CYCLES = 2,
    parameter bit IDLE_BIT   = 1'b1,
    localparam int LEN_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeats,
    input  logic             pause,
    output logic             x,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LD =
        (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam logic [LEN_W-1:0] WMAX = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] cap_pat;
    logic [LEN_W-1:0] cap_len;
    logic [LEN_W-1:0] bcnt;
    logic [CNT_W-1:0] fcnt;
    logic [GW-1:0]    gcnt;

    logic [LEN_W-1:0] shamt;
    logic [WIDTH-1:0] aligned;
    logic [WIDTH-1:0] nxt;
    logic             len_ok;

    // Left-justify the pattern so the frame's MSB sits at shreg[WIDTH-1].
    always_comb begin
        shamt   = WMAX - len;
        aligned = pattern << shamt;
        nxt     = shreg << 1;
        len_ok  = (len != '0) && (len <= WMAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cap_pat   <= '0;
            cap_len   <= '0;
            bcnt      <= '0;
            fcnt      <= '0;
            gcnt      <= '0;
            x         <= IDLE_BIT;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    x         <= IDLE_BIT;
                    bit_valid <= 1'b0;
                    busy      <= 1'b0;
                    if (start && len_ok) begin
                        cap_pat   <= aligned;
                        cap_len   <= len;
                        shreg     <= aligned;
                        bcnt      <= len;
                        fcnt      <= repeats;
                        x         <= aligned[WIDTH-1];
                        bit_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                SEND: begin
                    if (pause) begin
                        // The held bit stays on x but is not qualified again.
                        bit_valid <= 1'b0;
                    end else if (bcnt != ONE) begin
                        shreg     <= nxt;
                        bcnt      <= bcnt - ONE;
                        x         <= nxt[WIDTH-1];
                        bit_valid <= 1'b1;
                    end else if (fcnt != '0) begin
                        fcnt <= fcnt - 1'b1;
                        if (GAP_CYCLES > 0) begin
                            gcnt      <= GAP_LD;
                            x         <= IDLE_BIT;
                            bit_valid <= 1'b0;
                            state     <= GAP;
                        end else begin
                            shreg     <= cap_pat;
                            bcnt      <= cap_len;
                            x         <= cap_pat[WIDTH-1];
                            bit_valid <= 1'b1;
                        end
                    end else begin
                        x         <= IDLE_BIT;
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                GAP: begin
                    if (gcnt == '0) begin
                        shreg     <= cap_pat;
                        bcnt      <= cap_len;
                        x         <= cap_pat[WIDTH-1];
                        bit_valid <= 1'b1;
                        state     <= SEND;
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
                DONE: begin
                    x         <= IDLE_BIT;
                    bit_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: vector table plus scoreboard for serial_pattern_tx.
// Covers reset, framing, gaps, pause, err, ignored starts, mid-frame reset and back-to-back mode.
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] len = '0;
    logic [3:0] repeats = '0;
    logic       pause = 1'b0;

    logic x, bit_valid, busy, done, err;
    logic x0, bit_valid0, busy0, done0, err0;

    serial_pattern_tx #(.GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .len(len), .repeats(repeats), .pause(pause),
        .x(x), .bit_valid(bit_valid), .busy(busy),
        .done(done), .err(err)
    );

    serial_pattern_tx #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .len(len), .repeats(repeats), .pause(pause),
        .x(x0), .bit_valid(bit_valid0), .busy(busy0),
        .done(done0), .err(err0)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic x;
        logic bv;
        logic busy;
        logic done;
        logic err;
    } exp_t;

    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  len;
        logic [3:0]  rep;
        logic [31:0] xs;
        logic [31:0] vs;
        int          n;
        int          plo;
        int          phi;
        int          rs;
    } vec_t;

    exp_t sb[$];
    vec_t vt[9];
    int   nvec = 0;
    int   nbad = 0;

    localparam exp_t IDL = '{x: 1'b1, bv: 1'b0, busy: 1'b0,
                             done: 1'b0, err: 1'b0};
    localparam exp_t DNE = '{x: 1'b1, bv: 1'b0, busy: 1'b0,
                             done: 1'b1, err: 1'b0};
    localparam exp_t ERR = '{x: 1'b1, bv: 1'b0, busy: 1'b0,
                             done: 1'b0, err: 1'b1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input int c,
                       input exp_t act, input exp_t e);
        nvec++;
        if (act !== e) begin
            nbad++;
            $display("FAIL %s cyc %0d: got x/bv/busy/done/err=%b expected %b",
                     nm, c, act, e);
        end
    endtask

    function automatic exp_t cur();
        return '{x: x, bv: bit_valid, busy: busy, done: done, err: err};
    endfunction

    function automatic exp_t cur0();
        return '{x: x0, bv: bit_valid0, busy: busy0,
                 done: done0, err: err0};
    endfunction

    task automatic run_vec(input string nm, input vec_t v);
        exp_t e;
        int   c;
        pattern = v.pat;
        len     = v.len;
        repeats = v.rep;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        pattern = ~v.pat;
        repeats = 4'd3;
        for (int i = 0; i < v.n; i++) begin
            e = '{x: v.xs[v.n-1-i], bv: v.vs[v.n-1-i], busy: 1'b1,
                  done: 1'b0, err: 1'b0};
            sb.push_back(e);
        end
        sb.push_back(DNE);
        sb.push_back(IDL);
        c = 1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(nm, c, cur(), e);
            pause = (c >= v.plo) && (c <= v.phi);
            start = (c == v.rs);
            tick();
            c++;
        end
        pause = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while ((busy || done) && k < 200) begin
            tick();
            k++;
        end
        nvec++;
        if (busy || done) begin
            nbad++;
            $display("FAIL %s: busy=%b done=%b after 200 cycles, expected idle",
                     nm, busy, done);
        end
        tick();
    endtask

    initial begin
        exp_t e;
        vt[0] = '{8'hA6, 4'd8, 4'd0, 32'b10100110, 32'hFF, 8, 0, 0, 0};
        vt[1] = '{8'h02, 4'd3, 4'd1, 32'b01011010, 32'b11100111,
                  8, 0, 0, 0};
        vt[2] = '{8'hFE, 4'd1, 4'd2, 32'b0110110, 32'b1001001,
                  7, 0, 0, 0};
        vt[3] = '{8'hC5, 4'd5, 4'd0, 32'b00101, 32'b11111, 5, 0, 0, 0};
        vt[4] = '{8'h81, 4'd8, 4'd1, 32'b10000001_11_10000001,
                  32'b11111111_00_11111111, 18, 0, 0, 0};
        vt[5] = '{8'hA6, 4'd8, 4'd0, 32'b10100000110, 32'b11110001111,
                  11, 4, 6, 0};
        vt[6] = '{8'h02, 4'd3, 4'd1, 32'b01011010, 32'b11100111,
                  8, 4, 5, 0};
        vt[7] = '{8'hA6, 4'd8, 4'd0, 32'b10100110, 32'hFF, 8, 0, 0, 3};
        vt[8] = '{8'hA6, 4'd8, 4'd0, 32'b10100110, 32'hFF, 8, 0, 0, 9};

        rst     = 1'b1;
        start   = 1'b1;
        pattern = 8'hA6;
        len     = 4'd8;
        tick();
        cmp("reset", 1, cur(), IDL);
        tick();
        cmp("reset", 2, cur(), IDL);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        cmp("post_reset", 3, cur(), IDL);

        for (int i = 0; i < 9; i++)
            run_vec($sformatf("vec%0d", i), vt[i]);

        len   = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cmp("err_len0", 1, cur(), ERR);
        tick();
        cmp("err_len0", 2, cur(), IDL);
        len   = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        cmp("err_len9", 1, cur(), ERR);
        tick();
        cmp("err_len9", 2, cur(), IDL);

        pattern = 8'hA6;
        len     = 4'd8;
        repeats = 4'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            e = '{x: vt[0].xs[8-c], bv: 1'b1, busy: 1'b1,
                  done: 1'b0, err: 1'b0};
            cmp("rst_mid", c, cur(), e);
            if (c == 5) rst = 1'b1;
            tick();
        end
        cmp("rst_mid", 6, cur(), IDL);
        rst = 1'b0;
        tick();
        cmp("rst_mid", 7, cur(), IDL);
        run_vec("after_rst", vt[0]);

        pattern = 8'h02;
        len     = 4'd3;
        repeats = 4'd1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            e = '{x: (c == 2 || c == 5), bv: 1'b1, busy: 1'b1,
                  done: 1'b0, err: 1'b0};
            cmp("gap0", c, cur0(), e);
            tick();
        end
        cmp("gap0", 7, cur0(), DNE);
        tick();
        cmp("gap0", 8, cur0(), IDL);
        wait_idle("gap0_wait");

        pattern = 8'h00;
        len     = 4'd1;
        repeats = 4'd15;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            e = '{x: 1'b0, bv: 1'b1, busy: 1'b1, done: 1'b0, err: 1'b0};
            cmp("rep15", c, cur0(), e);
            tick();
        end
        cmp("rep15", 17, cur0(), DNE);
        tick();
        cmp("rep15", 18, cur0(), IDL);
        wait_idle("rep15_wait");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
